serv_axi_rd_arbiter: RTL

SERV_AXI_RD_ARBITER -- requirements
Module: serv_axi_rd_arbiter

---
 rtl/serv_axi_pkg.sv | 30 +++
 rtl/serv_axi_rr_arb.sv | 45 ++++
 rtl/serv_axi_rd_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/serv_axi_pkg.sv
// Shared types for the SERV AXI read-channel arbiter: FSM states,
// AXI burst/response encodings and the owner index.
package serv_axi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_t;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Owner index: 0 = S0 (instruction bus), 1 = S1 (data bus)
  typedef logic owner_t;
  localparam owner_t OWNER_S0 = 1'b0;
  localparam owner_t OWNER_S1 = 1'b1;

  // Convert a one-hot two-way grant into an owner index
  function automatic owner_t gnt_to_owner(input logic [1:0] gnt);
    return owner_t'(gnt[1]);
  endfunction

endpackage

// File: rtl/serv_axi_rr_arb.sv
// Two-requester grant logic with a one-hot grant.
// SERV_AXI_RD_ARB_RR_EN defined : round-robin, last winner loses ties,
//                                 pointer resets favouring request 0.
// SERV_AXI_RD_ARB_RR_EN undefined: fixed priority, request 1 over request 0.
module serv_axi_rr_arb (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_upd,
  output logic [1:0] o_gnt
);
`ifdef SERV_AXI_RD_ARB_RR_EN
  // 0: request 0 wins a tie, 1: request 1 wins a tie
  logic r_prio;

  // Grant the single requester, or the favoured one on a tie
  always_comb begin
    o_gnt = 2'b00;
    if (i_req == 2'b11)
      o_gnt = r_prio ? 2'b10 : 2'b01;
    else
      o_gnt = i_req;
  end

  // Favour the port that did not win the most recent grant
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_prio <= 1'b0;
    else if (i_upd && (|o_gnt))
      r_prio <= o_gnt[0];
  end
`else
  logic w_unused;
  assign w_unused = ^{i_clk, i_rst, i_upd};

  // Data bus (request 1) always beats instruction bus (request 0)
  always_comb begin
    o_gnt = 2'b00;
    if (i_req[1])
      o_gnt = 2'b10;
    else if (i_req[0])
      o_gnt = 2'b01;
  end
`endif
endmodule

// File: rtl/serv_axi_rd_arbiter.sv
// Arbitrates the SERV instruction-bus (S0) and data-bus (S1) AXI read
// channels onto one master read port, one transaction outstanding.
// Optional macro SERV_AXI_RD_ARB_RR_EN selects round-robin arbitration;
// otherwise S1 has fixed priority over S0.
module serv_axi_rd_arbiter
  import serv_axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  // S0: instruction bus
  input  logic [ID_WIDTH-1:0]   S0_AXI_arid,
  input  logic [ADDR_WIDTH-1:0] S0_AXI_araddr,
  input  logic [7:0]            S0_AXI_arlen,
  input  logic [2:0]            S0_AXI_arsize,
  input  logic [1:0]            S0_AXI_arburst,
  input  logic [2:0]            S0_AXI_arprot,
  input  logic                  S0_AXI_arvalid,
  output logic                  S0_AXI_arready,
  output logic [ID_WIDTH-1:0]   S0_AXI_rid,
  output logic [DATA_WIDTH-1:0] S0_AXI_rdata,
  output logic [1:0]            S0_AXI_rresp,
  output logic                  S0_AXI_rlast,
  output logic                  S0_AXI_rvalid,
  input  logic                  S0_AXI_rready,
  // S1: data bus
  input  logic [ID_WIDTH-1:0]   S1_AXI_arid,
  input  logic [ADDR_WIDTH-1:0] S1_AXI_araddr,
  input  logic [7:0]            S1_AXI_arlen,
  input  logic [2:0]            S1_AXI_arsize,
  input  logic [1:0]            S1_AXI_arburst,
  input  logic [2:0]            S1_AXI_arprot,
  input  logic                  S1_AXI_arvalid,
  output logic                  S1_AXI_arready,
  output logic [ID_WIDTH-1:0]   S1_AXI_rid,
  output logic [DATA_WIDTH-1:0] S1_AXI_rdata,
  output logic [1:0]            S1_AXI_rresp,
  output logic                  S1_AXI_rlast,
  output logic                  S1_AXI_rvalid,
  input  logic                  S1_AXI_rready,
  // Shared master port
  output logic [ID_WIDTH-1:0]   M_AXI_arid,
  output logic [ADDR_WIDTH-1:0] M_AXI_araddr,
  output logic [7:0]            M_AXI_arlen,
  output logic [2:0]            M_AXI_arsize,
  output logic [1:0]            M_AXI_arburst,
  output logic [2:0]            M_AXI_arprot,
  output logic                  M_AXI_arvalid,
  input  logic                  M_AXI_arready,
  input  logic [ID_WIDTH-1:0]   M_AXI_rid,
  input  logic [DATA_WIDTH-1:0] M_AXI_rdata,
  input  logic [1:0]            M_AXI_rresp,
  input  logic                  M_AXI_rlast,
  input  logic                  M_AXI_rvalid,
  output logic                  M_AXI_rready
);

  arb_state_t            r_state;
  owner_t                r_owner;
  logic [ID_WIDTH-1:0]   r_arid;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic [7:0]            r_arlen;
  logic [2:0]            r_arsize;
  logic [1:0]            r_arburst;
  logic [2:0]            r_arprot;

  logic [1:0] w_req;
  logic [1:0] w_gnt;
  logic       w_idle;
  logic       w_own0;
  logic       w_own1;

  assign w_req  = {S1_AXI_arvalid, S0_AXI_arvalid};
  assign w_idle = (r_state == ST_IDLE);
  assign w_own0 = (r_state == ST_DATA) && (r_owner == OWNER_S0);
  assign w_own1 = (r_state == ST_DATA) && (r_owner == OWNER_S1);

  serv_axi_rr_arb u_arb (
    .i_clk (ACLK),
    .i_rst (ARESET),
    .i_req (w_req),
    .i_upd (w_idle),
    .o_gnt (w_gnt)
  );

  // AR accept only while idle and out of reset, to the winner alone
  assign S0_AXI_arready = w_idle & ~ARESET & w_gnt[0];
  assign S1_AXI_arready = w_idle & ~ARESET & w_gnt[1];

  assign M_AXI_arvalid = (r_state == ST_ADDR);
  assign M_AXI_arid    = r_arid;
  assign M_AXI_araddr  = r_araddr;
  assign M_AXI_arlen   = r_arlen;
  assign M_AXI_arsize  = r_arsize;
  assign M_AXI_arburst = r_arburst;
  assign M_AXI_arprot  = r_arprot;

  assign M_AXI_rready = (w_own0 & S0_AXI_rready) | (w_own1 & S1_AXI_rready);

  // R channel is steered to the owner; the other port sees all zeros
  assign S0_AXI_rvalid = w_own0 & M_AXI_rvalid;
  assign S0_AXI_rlast  = w_own0 & M_AXI_rlast;
  assign S0_AXI_rid    = w_own0 ? M_AXI_rid   : '0;
  assign S0_AXI_rdata  = w_own0 ? M_AXI_rdata : '0;
  assign S0_AXI_rresp  = w_own0 ? M_AXI_rresp : '0;
  assign S1_AXI_rvalid = w_own1 & M_AXI_rvalid;
  assign S1_AXI_rlast  = w_own1 & M_AXI_rlast;
  assign S1_AXI_rid    = w_own1 ? M_AXI_rid   : '0;
  assign S1_AXI_rdata  = w_own1 ? M_AXI_rdata : '0;
  assign S1_AXI_rresp  = w_own1 ? M_AXI_rresp : '0;

  // Transaction FSM: latch winner in IDLE, issue in ADDR, forward beats in DATA
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state   <= ST_IDLE;
      r_owner   <= OWNER_S0;
      r_arid    <= '0;
      r_araddr  <= '0;
      r_arlen   <= '0;
      r_arsize  <= '0;
      r_arburst <= '0;
      r_arprot  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_gnt) begin
            r_state   <= ST_ADDR;
            r_owner   <= gnt_to_owner(w_gnt);
            r_arid    <= w_gnt[1] ? S1_AXI_arid    : S0_AXI_arid;
            r_araddr  <= w_gnt[1] ? S1_AXI_araddr  : S0_AXI_araddr;
            r_arlen   <= w_gnt[1] ? S1_AXI_arlen   : S0_AXI_arlen;
            r_arsize  <= w_gnt[1] ? S1_AXI_arsize  : S0_AXI_arsize;
            r_arburst <= w_gnt[1] ? S1_AXI_arburst : S0_AXI_arburst;
            r_arprot  <= w_gnt[1] ? S1_AXI_arprot  : S0_AXI_arprot;
          end
        end
        ST_ADDR: begin
          if (M_AXI_arready)
            r_state <= ST_DATA;
        end
        ST_DATA: begin
          if (M_AXI_rvalid && M_AXI_rready && M_AXI_rlast)
            r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
